// File: rtl/midi_parser.sv
// Monophonic MIDI note parser: turns a received byte stream into note,
// velocity, gate and a note-event strobe, with running status and last-note priority.
module midi_parser #(
  parameter bit CHANNEL_FILTER = 1'b1
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic [7:0] byte_i,
  input  logic       byteValid_i,
  input  logic [3:0] channel_i,
  output logic [6:0] note_o,
  output logic [6:0] velocity_o,
  output logic       gate_o,
  output logic       noteEvent_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NOTE_D1 = 3'd1,
    NOTE_D2 = 3'd2,
    SKIP_D1 = 3'd3,
    SKIP_D2 = 3'd4
  } state_e;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_PROG_CHG = 4'hC;
  localparam logic [3:0] ST_CHAN_AT  = 4'hD;

  state_e     state_q, state_d;
  logic [3:0] status_q, status_d;     // running-status message type (upper nibble)
  logic [6:0] pend_note_q, pend_note_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       event_q, event_d;

  logic is_realtime, is_syscommon, is_status, is_note_status, chan_match;

  assign is_realtime    = (byte_i >= 8'hF8);
  assign is_syscommon   = (byte_i >= 8'hF0) && !is_realtime;
  assign is_status      = byte_i[7] && (byte_i < 8'hF0);
  assign is_note_status = (byte_i[7:4] == ST_NOTE_OFF) || (byte_i[7:4] == ST_NOTE_ON);
  assign chan_match     = !CHANNEL_FILTER || (byte_i[3:0] == channel_i);

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    pend_note_d = pend_note_q;
    note_d      = note_q;
    vel_d       = vel_q;
    gate_d      = gate_q;
    event_d     = 1'b0;

    if (byteValid_i && !is_realtime) begin
      if (is_syscommon) begin
        state_d  = IDLE;
        status_d = 4'h0;
      end else if (is_status) begin
        status_d = byte_i[7:4];
        state_d  = (is_note_status && chan_match) ? NOTE_D1 : SKIP_D1;
      end else begin
        unique case (state_q)
          NOTE_D1: begin
            pend_note_d = byte_i[6:0];
            state_d     = NOTE_D2;
          end
          NOTE_D2: begin
            state_d = NOTE_D1;
            if (status_q == ST_NOTE_ON && byte_i[6:0] != 7'd0) begin
              note_d  = pend_note_q;
              vel_d   = byte_i[6:0];
              gate_d  = 1'b1;
              event_d = 1'b1;
            end else if (pend_note_q == note_q) begin
              // Release only when the note-off names the note currently sounding.
              vel_d   = 7'd0;
              gate_d  = 1'b0;
              event_d = 1'b1;
            end
          end
          SKIP_D1: begin
            if (status_q != ST_PROG_CHG && status_q != ST_CHAN_AT) begin
              state_d = SKIP_D2;
            end
          end
          SKIP_D2: state_d = SKIP_D1;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the async reset clears all of it immediately.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= IDLE;
      status_q    <= 4'h0;
      pend_note_q <= 7'd0;
      note_q      <= 7'd0;
      vel_q       <= 7'd0;
      gate_q      <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      pend_note_q <= pend_note_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      gate_q      <= gate_d;
      event_q     <= event_d;
    end
  end

  assign note_o      = note_q;
  assign velocity_o  = vel_q;
  assign gate_o      = gate_q;
  assign noteEvent_o = event_q;

endmodule

// File: tb/tb_midi_parser.sv
// Bench for midi_parser: a filtered and an omni instance share one byte stream;
// a message-level model is compared every cycle, plus literal spot checks.
module tb_midi_parser;

  logic       clk_i = 1'b0;
  logic       nrst_i;
  logic [7:0] byte_i;
  logic       byteValid_i;
  logic [3:0] channel_i;

  logic [6:0] f_note, f_vel, o_note, o_vel;
  logic       f_gate, f_ev, o_gate, o_ev;

  int checks = 0;
  int errors = 0;

  midi_parser #(.CHANNEL_FILTER(1'b1)) u_filt (
    .clk_i(clk_i), .nrst_i(nrst_i), .byte_i(byte_i), .byteValid_i(byteValid_i),
    .channel_i(channel_i), .note_o(f_note), .velocity_o(f_vel),
    .gate_o(f_gate), .noteEvent_o(f_ev)
  );

  midi_parser #(.CHANNEL_FILTER(1'b0)) u_omni (
    .clk_i(clk_i), .nrst_i(nrst_i), .byte_i(byte_i), .byteValid_i(byteValid_i),
    .channel_i(channel_i), .note_o(o_note), .velocity_o(o_vel),
    .gate_o(o_gate), .noteEvent_o(o_ev)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Message-level model, index 0 = filtered instance, 1 = omni instance.
  // Bytes of a message are collected into a buffer and acted on once complete.
  logic [6:0] m_note [2];
  logic [6:0] m_vel  [2];
  logic       m_gate [2];
  logic       m_ev   [2];
  bit         m_active [2];   // a running status is known
  bit         m_is_note[2];   // that status is an accepted note message
  bit         m_is_on  [2];
  int         m_need   [2];
  int         m_cnt    [2];
  logic [6:0] m_buf    [2][2];

  task automatic model_byte(input int k, input logic [7:0] b, input logic [3:0] ch);
    logic [3:0] hi;
    bit filt;
    filt = (k == 0);
    hi   = b[7:4];
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_active[k] = 0;
      m_cnt[k]    = 0;
    end else if (b[7]) begin
      m_active[k]  = 1;
      m_cnt[k]     = 0;
      m_is_note[k] = (hi == 4'h8 || hi == 4'h9) && (!filt || b[3:0] == ch);
      m_is_on[k]   = (hi == 4'h9);
      m_need[k]    = (!m_is_note[k] && (hi == 4'hC || hi == 4'hD)) ? 1 : 2;
    end else if (m_active[k]) begin
      m_buf[k][m_cnt[k]] = b[6:0];
      m_cnt[k]++;
      if (m_cnt[k] == m_need[k]) begin
        m_cnt[k] = 0;
        if (m_is_note[k]) begin
          if (m_is_on[k] && m_buf[k][1] != 0) begin
            m_note[k] = m_buf[k][0];
            m_vel[k]  = m_buf[k][1];
            m_gate[k] = 1;
            m_ev[k]   = 1;
          end else if (m_buf[k][0] == m_note[k]) begin
            m_vel[k]  = 0;
            m_gate[k] = 0;
            m_ev[k]   = 1;
          end
        end
      end
    end
  endtask

  always @(posedge clk_i or negedge nrst_i) begin
    for (int k = 0; k < 2; k++) begin
      if (!nrst_i) begin
        m_note[k] = 0; m_vel[k] = 0; m_gate[k] = 0; m_ev[k] = 0;
        m_active[k] = 0; m_is_note[k] = 0; m_is_on[k] = 0;
        m_need[k] = 2; m_cnt[k] = 0;
      end else begin
        m_ev[k] = 0;
        if (byteValid_i) model_byte(k, byte_i, channel_i);
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk_i) begin
    check("filt.note", {25'd0, f_note}, {25'd0, m_note[0]});
    check("filt.vel",  {25'd0, f_vel},  {25'd0, m_vel[0]});
    check("filt.gate", {31'd0, f_gate}, {31'd0, m_gate[0]});
    check("filt.ev",   {31'd0, f_ev},   {31'd0, m_ev[0]});
    check("omni.note", {25'd0, o_note}, {25'd0, m_note[1]});
    check("omni.vel",  {25'd0, o_vel},  {25'd0, m_vel[1]});
    check("omni.gate", {31'd0, o_gate}, {31'd0, m_gate[1]});
    check("omni.ev",   {31'd0, o_ev},   {31'd0, m_ev[1]});
  end

  // Called at posedge+1; returns at the posedge+1 of the edge consuming b.
  task automatic send(input logic [7:0] b);
    byte_i      = b;
    byteValid_i = 1'b1;
    @(posedge clk_i);
    #1;
    byteValid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic pulse_reset();
    nrst_i = 1'b0;
    #2;
    nrst_i = 1'b1;
    idle(1);
  endtask

  task automatic lit(input string name, input logic [6:0] note, input logic [6:0] vel,
                     input logic gate, input logic ev);
    check({name, ".note"}, {25'd0, f_note}, {25'd0, note});
    check({name, ".vel"},  {25'd0, f_vel},  {25'd0, vel});
    check({name, ".gate"}, {31'd0, f_gate}, {31'd0, gate});
    check({name, ".ev"},   {31'd0, f_ev},   {31'd0, ev});
  endtask

  initial begin
    nrst_i      = 1'b0;
    byteValid_i = 1'b0;
    byte_i      = 8'h00;
    channel_i   = 4'd0;
    #2;
    lit("reset", 7'h00, 7'h00, 1'b0, 1'b0);
    check("reset.omni_gate", {31'd0, o_gate}, 32'd0);
    @(posedge clk_i);
    #1;
    nrst_i = 1'b1;
    idle(2);

    // Note-on with gaps between bytes, then a one-cycle event pulse.
    send(8'h90); idle(1); send(8'h3C); idle(2); send(8'h64);
    lit("on1", 7'h3C, 7'h64, 1'b1, 1'b1);
    idle(1);
    lit("on1_after", 7'h3C, 7'h64, 1'b1, 1'b0);

    // Running status: new note, then a non-matching release, then a matching one.
    send(8'h40); send(8'h50);
    lit("run_on", 7'h40, 7'h50, 1'b1, 1'b1);
    send(8'h3C); send(8'h00);
    lit("stale_off", 7'h40, 7'h50, 1'b1, 1'b0);
    send(8'h40); send(8'h00);
    lit("off", 7'h40, 7'h00, 1'b0, 1'b1);
    idle(1);

    // Channel filter: channel 2 message is ignored by the filtered instance only.
    pulse_reset();
    send(8'h91); send(8'h3C); send(8'h64);
    lit("filt_ch2", 7'h00, 7'h00, 1'b0, 1'b0);
    check("omni_ch2.gate", {31'd0, o_gate}, 32'd1);
    check("omni_ch2.note", {25'd0, o_note}, 32'h3C);
    idle(1);

    // Matching non-zero channel, and a note-off via 0x8n status.
    channel_i = 4'd5;
    send(8'h95); send(8'h22); send(8'h33);
    lit("ch6_on", 7'h22, 7'h33, 1'b1, 1'b1);
    send(8'h85); send(8'h22); send(8'h40);
    lit("ch6_off", 7'h22, 7'h00, 1'b0, 1'b1);
    channel_i = 4'd0;
    idle(1);

    // Realtime byte inside a message, then a system common byte kills running status.
    pulse_reset();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    lit("rt_on", 7'h3C, 7'h64, 1'b1, 1'b1);
    send(8'hF0); send(8'h3C); send(8'h64);
    lit("sysc", 7'h3C, 7'h64, 1'b1, 1'b0);
    idle(1);

    // Program change (one data byte) skipped, then a note-on.
    pulse_reset();
    send(8'hC0); send(8'h05); send(8'h07); send(8'h90); send(8'h30); send(8'h10);
    lit("pc_skip", 7'h30, 7'h10, 1'b1, 1'b1);

    // Status in SKIP_D2 and NOTE_D2 aborts the partial message.
    send(8'hB0); send(8'h07); send(8'h90); send(8'h41); send(8'h22);
    lit("abort_skip", 7'h41, 7'h22, 1'b1, 1'b1);
    send(8'h90); send(8'h3C); send(8'h90); send(8'h3D); send(8'h20);
    lit("abort_note", 7'h3D, 7'h20, 1'b1, 1'b1);
    idle(1);

    // Reset in the middle of a message; the trailing data byte is ignored.
    pulse_reset();
    send(8'h90); send(8'h3C);
    pulse_reset();
    send(8'h64);
    idle(1);
    lit("mid_reset", 7'h00, 7'h00, 1'b0, 1'b0);

    // Three consecutive strobes, then byte_i toggling with no strobe.
    send(8'h90); send(8'h3C); send(8'h64);
    lit("b2b", 7'h3C, 7'h64, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      byte_i = (i % 2 == 0) ? 8'h80 : 8'h3C;
      idle(1);
    end
    byte_i = 8'h00;
    lit("no_strobe", 7'h3C, 7'h64, 1'b1, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_parser.md
MIDI_PARSER -- requirements
Module: midi_parser

Interface
REQ-001 Parameter: CHANNEL_FILTER, default 1; 1 = accept only channel channel_i, 0 = omni (accept all 16 channels).
REQ-002 Port: clk_i  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: nrst_i  input  1  asynchronous, active-low reset.
REQ-004 Port: byte_i  input  8  received MIDI byte from the serial RX frontend.
REQ-005 Port: byteValid_i  input  1  one-cycle strobe; byte_i is valid in this cycle only.
REQ-006 Port: channel_i  input  4  MIDI channel to accept (0 = channel 1); sampled when a status byte arrives.
REQ-007 Port: note_o  output  7  note number of the current or last note.
REQ-008 Port: velocity_o  output  7  velocity of the last accepted note-on; 0 after a note-off.
REQ-009 Port: gate_o  output  1  high while the current note is held (monophonic, last-note priority).
REQ-010 Port: noteEvent_o  output  1  one-cycle pulse on every accepted note-on or note-off.

Function
REQ-011 Bytes are processed only in cycles with byteValid_i=1; all other cycles hold every state and output, except that noteEvent_o returns to 0.
REQ-012 Byte classes: data = 0x00-0x7F; channel status = 0x80-0xEF; system common = 0xF0-0xF7; realtime = 0xF8-0xFF.
REQ-013 FSM states: IDLE (no running status), NOTE_D1, NOTE_D2, SKIP_D1, SKIP_D2.
REQ-014 Realtime byte, any state: ignored; no change to state, running status or outputs.
REQ-015 System common byte, any state: go to IDLE and clear running status.
REQ-016 Status 0x8n or 0x9n, with n == channel_i or CHANNEL_FILTER == 0, any state: store the status, go to NOTE_D1.
REQ-017 Any other channel status, including note status on a non-matching channel: store the status, go to SKIP_D1.
REQ-018 Data byte in IDLE: ignored, state unchanged.
REQ-019 Data byte in NOTE_D1: latch it as the pending note, go to NOTE_D2.
REQ-020 Data byte in NOTE_D2: latch it as the pending velocity, evaluate per REQ-022/023, and go to NOTE_D1 (running status).
REQ-021 SKIP_D1 data byte: go to SKIP_D2 for stored status 0x8-0xB or 0xE; stay in SKIP_D1 for 0xC or 0xD. SKIP_D2 data byte: go to SKIP_D1. No output change in either state.
REQ-022 Note-on: status 0x9n with velocity != 0. On the edge after the NOTE_D2 byte: note_o = pending note, velocity_o = velocity, gate_o = 1, noteEvent_o = 1.
REQ-023 Note-off: status 0x8n, or 0x9n with velocity 0. If pending note == note_o: gate_o = 0, velocity_o = 0, noteEvent_o = 1. Otherwise no output change and no pulse.
REQ-024 Latency: outputs update on the same rising edge that consumes the second data byte; noteEvent_o is high for exactly that following cycle.
REQ-025 A status byte arriving in NOTE_D2 or SKIP_D2 aborts the partial message without output change, then is handled per REQ-016/017.
REQ-026 Back-to-back strobes on consecutive cycles are legal; every byte is processed.

Reset
REQ-027 While nrst_i=0, immediately and independent of clk_i: state = IDLE, running status cleared, pending note/velocity = 0, note_o = 0, velocity_o = 0, gate_o = 0, noteEvent_o = 0.
REQ-028 Reset asserted mid-message discards the partial message; the first data byte after release is ignored per REQ-018.

Verification
REQ-029 channel_i=0; bytes 0x90,0x3C,0x64 -> one cycle after the 3rd strobe: note_o=0x3C, velocity_o=0x64, gate_o=1, noteEvent_o pulses for 1 cycle.
REQ-030 Continue with 0x40,0x50 (running status) -> note_o=0x40, velocity_o=0x50, gate_o=1; then 0x3C,0x00 -> no pulse, gate_o stays 1; then 0x40,0x00 -> gate_o=0, velocity_o=0, pulse.
REQ-031 channel_i=0, CHANNEL_FILTER=1; 0x91,0x3C,0x64 -> no output change. Same sequence with CHANNEL_FILTER=0 -> note-on accepted.
REQ-032 0x90,0x3C,0xF8,0x64 -> note-on accepted exactly as in REQ-029. Then 0xF0,0x3C,0x64 -> ignored.
REQ-033 0xC0,0x05,0x07 then 0x90,0x30,0x10 -> program change skipped; note 0x30 accepted. Also: 0x90,0x3C, reset pulse, 0x64 -> all outputs remain 0.
REQ-034 Strobes on three consecutive cycles (0x90,0x3C,0x64) -> same response as REQ-029; byteValid_i=0 with byte_i toggling -> no state change.
